// File: rtl/clb_cfg_pkg.sv
// -----------------------------------------------------------------------------
// clb_cfg_pkg
// Shared constants and types for the CLB serial configuration loader.
//   - Frame geometry: sync word, configuration word and checksum widths.
//   - SYNC pattern and the CLB power-up configuration (CFG_RST).
//   - Bit offsets/widths of every field inside the configuration word.
//   - Loader state encoding.
// -----------------------------------------------------------------------------
package clb_cfg_pkg;

    localparam int CFG_W  = 37;
    localparam int SYNC_W = 8;
    localparam int CHK_W  = 8;

    localparam logic [SYNC_W-1:0] SYNC    = 8'hB5;
    localparam logic [CFG_W-1:0]  CFG_RST = 37'h0022D50038;

    // One bit counter serves both the data and checksum phases, so it is
    // sized for the longer of the two.
    localparam int CNT_W = $clog2((CFG_W > CHK_W) ? CFG_W : CHK_W);

    // Configuration word field layout (LSB position and width).
    localparam int LUT_LSB        = 21;
    localparam int LUT_W          = 16;
    localparam int MUX2SEL_LSB    = 19;
    localparam int MUX3SEL_LSB    = 17;
    localparam int MUX4SEL_LSB    = 15;
    localparam int MUX5SEL_LSB    = 13;
    localparam int MUX6SEL_LSB    = 11;
    localparam int MUXSEL_W       = 2;
    localparam int COMBOOPT_LSB   = 9;
    localparam int COMBOOPT_W     = 2;
    localparam int O2M_0_LSB      = 6;
    localparam int O2M_1_LSB      = 3;
    localparam int O2M_W          = 3;
    localparam int DQMUX1_BIT     = 2;
    localparam int DQMUX2_BIT     = 1;
    localparam int FLOPORLATCH_BIT = 0;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        CHK  = 2'd2
    } state_t;

endpackage

// File: rtl/clb_cfg_chk.sv
// -----------------------------------------------------------------------------
// clb_cfg_chk
// Ones-count accumulator used as the frame checksum.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, clears the sum
//   clr    : synchronous clear (start of a new frame), wins over en
//   en     : add bit_in to the sum this cycle
//   bit_in : data bit being counted
//   sum    : running count of ones, modulo 2^SUM_W
// -----------------------------------------------------------------------------
module clb_cfg_chk
    import clb_cfg_pkg::*;
#(
    parameter int SUM_W = CHK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [SUM_W-1:0] sum
);

    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;

    // Next sum: clear takes priority so a sync detected on the same edge
    // always starts the new frame from zero.
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (en) begin
            sum_d = sum_q + SUM_W'(bit_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
// Serial configuration loader for the CLB. Hunts the DIN stream for the SYNC
// word, deserialises one CFG_W-bit configuration frame MSB first, then
// receives a CHK_W-bit ones-count checksum. A frame whose checksum matches is
// committed atomically to CFG; a mismatch leaves CFG alone and sets ERR.
//   K         : clock, rising edge
//   RST       : asynchronous active-high reset (CFG returns to CFG_RST)
//   DIN       : serial configuration data, MSB first
//   DVAL      : DIN qualifier, a bit is consumed only when high
//   CFG       : committed configuration word driving the CLB
//   CFG_VALID : a frame has been committed since reset
//   DONE      : one-cycle pulse after a commit
//   ERR       : sticky checksum failure, cleared by a commit or reset
//   BUSY      : loader is inside a frame (DATA or CHK)
// -----------------------------------------------------------------------------
module clb_cfg_loader
    import clb_cfg_pkg::*;
(
    input  logic             K,
    input  logic             RST,
    input  logic             DIN,
    input  logic             DVAL,
    output logic [CFG_W-1:0] CFG,
    output logic             CFG_VALID,
    output logic             DONE,
    output logic             ERR,
    output logic             BUSY
);

    state_t            state_q, state_d;
    logic [SYNC_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CFG_W-1:0]  frame_q, frame_d;
    logic [CHK_W-1:0]  rx_chk_q, rx_chk_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic              cfg_valid_q, cfg_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              acc_clr;
    logic              acc_en;
    logic [CHK_W-1:0]  acc_sum;
    logic [SYNC_W-1:0] sh_next;
    logic [CHK_W-1:0]  rx_chk_next;

    clb_cfg_chk #(
        .SUM_W (CHK_W)
    ) u_chk (
        .clk    (K),
        .rst    (RST),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (DIN),
        .sum    (acc_sum)
    );

    // Next-state and datapath control. Nothing moves unless DVAL is high,
    // so arbitrarily long gaps are transparent in every state.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        rx_chk_d    = rx_chk_q;
        cfg_d       = cfg_q;
        cfg_valid_d = cfg_valid_q;
        done_d      = 1'b0;
        err_d       = err_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        sh_next     = {sh_q[SYNC_W-2:0], DIN};
        rx_chk_next = {rx_chk_q[CHK_W-2:0], DIN};

        if (DVAL) begin
            case (state_q)
                HUNT: begin
                    if (sh_next == SYNC) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                        sh_d    = '0;
                    end else begin
                        sh_d = sh_next;
                    end
                end

                DATA: begin
                    frame_d = {frame_q[CFG_W-2:0], DIN};
                    acc_en  = 1'b1;
                    if (cnt_q == CNT_W'(CFG_W - 1)) begin
                        state_d = CHK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                CHK: begin
                    rx_chk_d = rx_chk_next;
                    if (cnt_q == CNT_W'(CHK_W - 1)) begin
                        // The final checksum bit is taken straight from DIN
                        // so the decision lands on the same edge.
                        if (rx_chk_next == acc_sum) begin
                            cfg_d       = frame_q;
                            cfg_valid_d = 1'b1;
                            err_d       = 1'b0;
                            done_d      = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = HUNT;
                        cnt_d   = '0;
                        sh_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            endcase
        end
    end

    // State registers; reset restores the power-up configuration at once.
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            state_q     <= HUNT;
            sh_q        <= '0;
            cnt_q       <= '0;
            frame_q     <= '0;
            rx_chk_q    <= '0;
            cfg_q       <= CFG_RST;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            rx_chk_q    <= rx_chk_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign CFG       = cfg_q;
    assign CFG_VALID = cfg_valid_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign BUSY      = (state_q == DATA) || (state_q == CHK);

endmodule

// File: tb/tb_clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_clb_cfg_loader
// Self-checking bench for clb_cfg_loader. Frame stimulus pushes the expected
// commit/error event into a queue; an independent monitor pops and compares
// whenever the DUT raises DONE or ERR.
// -----------------------------------------------------------------------------
module tb_clb_cfg_loader;

    localparam logic [36:0] CFG_RST_V = 37'h0022D50038;

    typedef struct packed {
        logic        is_err;
        logic [36:0] cfg;
        logic        valid;
        logic        err;
    } exp_t;

    logic        K;
    logic        RST;
    logic        DIN;
    logic        DVAL;
    logic [36:0] CFG;
    logic        CFG_VALID;
    logic        DONE;
    logic        ERR;
    logic        BUSY;

    int          check_count;
    int          pass_count;
    exp_t        exp_q[$];
    logic [36:0] model_cfg;
    logic        model_valid;
    logic        err_prev;

    clb_cfg_loader dut (
        .K         (K),
        .RST       (RST),
        .DIN       (DIN),
        .DVAL      (DVAL),
        .CFG       (CFG),
        .CFG_VALID (CFG_VALID),
        .DONE      (DONE),
        .ERR       (ERR),
        .BUSY      (BUSY)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        K = 1'b0;
        forever #5 K = ~K;
    end

    // Compare one value and keep the running tallies.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present one qualified bit; returns just after the consuming edge.
    task automatic sendBit(input logic b);
        @(negedge K);
        DIN  = b;
        DVAL = 1'b1;
        @(posedge K);
        #1;
    endtask

    // Hold DVAL low for n cycles with junk on DIN.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge K);
            DVAL = 1'b0;
            DIN  = 1'($urandom_range(0, 1));
        end
    endtask

    // Send sync, data and checksum; optional random gaps inside DATA.
    // The expected event is queued first so the monitor is never ahead.
    task automatic applyStimulus(input logic [36:0] data, input logic [7:0] chk,
                                 input logic good, input int max_gap);
        exp_t e;
        logic [7:0] sync_v;
        sync_v = 8'hB5;
        if (good) begin
            model_cfg   = data;
            model_valid = 1'b1;
        end
        e.is_err = !good;
        e.cfg    = model_cfg;
        e.valid  = model_valid;
        e.err    = !good;
        exp_q.push_back(e);

        for (int i = 7; i >= 0; i--) sendBit(sync_v[i]);
        checkOutput("busy_in_data", 64'(BUSY), 64'd1);
        for (int i = 36; i >= 0; i--) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            sendBit(data[i]);
        end
        checkOutput("busy_in_chk", 64'(BUSY), 64'd1);
        for (int i = 7; i >= 0; i--) sendBit(chk[i]);
        checkOutput("busy_after_frame", 64'(BUSY), 64'd0);
    endtask

    // Monitor: any DONE pulse or rising ERR must match the head of the queue.
    initial begin
        exp_t e;
        err_prev = 1'b0;
        forever begin
            @(negedge K);
            if (!RST && (DONE || (ERR && !err_prev))) begin
                if (exp_q.size() == 0) begin
                    check_count++;
                    $display("[TB] FAIL unexpected_event: DONE=%b ERR=%b with nothing expected",
                             DONE, ERR);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_is_err", 64'(!DONE), 64'(e.is_err));
                    checkOutput("event_cfg", 64'(CFG), 64'(e.cfg));
                    checkOutput("event_cfg_valid", 64'(CFG_VALID), 64'(e.valid));
                    checkOutput("event_err", 64'(ERR), 64'(e.err));
                end
            end
            err_prev = ERR;
        end
    end

    // Directed test sequence.
    initial begin
        logic [36:0] part;
        logic [7:0]  noise;
        check_count = 0;
        pass_count  = 0;
        model_cfg   = CFG_RST_V;
        model_valid = 1'b0;
        RST  = 1'b1;
        DIN  = 1'b0;
        DVAL = 1'b0;

        // Reset values before any clock edge.
        #2;
        checkOutput("rst_cfg", 64'(CFG), 64'(CFG_RST_V));
        checkOutput("rst_cfg_valid", 64'(CFG_VALID), 64'd0);
        checkOutput("rst_done", 64'(DONE), 64'd0);
        checkOutput("rst_err", 64'(ERR), 64'd0);
        checkOutput("rst_busy", 64'(BUSY), 64'd0);
        idle(2);
        RST = 1'b0;
        idle(2);

        // Good frame carrying the power-up value, then a back-to-back frame.
        $display("[TB] good frames");
        applyStimulus(37'h0022D50038, 8'h0A, 1'b1, 0);
        applyStimulus(37'h1FFFFFFFFF, 8'h25, 1'b1, 0);
        idle(3);
        checkOutput("cfg_after_ones", 64'(CFG), 64'h1FFFFFFFFF);

        // Bad checksum keeps CFG and sets ERR without DONE.
        $display("[TB] bad checksum");
        applyStimulus(37'h0000000001, 8'h00, 1'b0, 0);
        idle(3);
        checkOutput("cfg_kept_on_err", 64'(CFG), 64'h1FFFFFFFFF);
        checkOutput("err_sticky", 64'(ERR), 64'd1);

        // Noise: idle ones and a near-miss pattern must not sync.
        $display("[TB] noise and gaps");
        for (int i = 0; i < 9; i++) sendBit(1'b1);
        noise = 8'hB4;
        for (int i = 7; i >= 0; i--) sendBit(noise[i]);
        idle(4);
        checkOutput("busy_after_noise", 64'(BUSY), 64'd0);
        applyStimulus(37'h15A5A5A5A5, 8'h13, 1'b1, 3);
        idle(3);
        checkOutput("err_cleared", 64'(ERR), 64'd0);
        checkOutput("cfg_gap_frame", 64'(CFG), 64'h15A5A5A5A5);

        // Reset mid-frame, then the rest of the frame without a sync.
        $display("[TB] reset mid-frame");
        part = 37'h0000000000;
        noise = 8'hB5;
        for (int i = 7; i >= 0; i--) sendBit(noise[i]);
        for (int i = 36; i >= 17; i--) sendBit(part[i]);
        @(negedge K);
        DVAL = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        checkOutput("midrst_cfg", 64'(CFG), 64'(CFG_RST_V));
        checkOutput("midrst_cfg_valid", 64'(CFG_VALID), 64'd0);
        checkOutput("midrst_busy", 64'(BUSY), 64'd0);
        checkOutput("midrst_err", 64'(ERR), 64'd0);
        idle(2);
        RST = 1'b0;
        model_cfg   = CFG_RST_V;
        model_valid = 1'b0;
        for (int i = 16; i >= 0; i--) sendBit(part[i]);
        for (int i = 0; i < 8; i++) sendBit(1'b0);
        idle(5);
        checkOutput("post_rst_busy", 64'(BUSY), 64'd0);
        checkOutput("post_rst_cfg", 64'(CFG), 64'(CFG_RST_V));
        checkOutput("post_rst_cfg_valid", 64'(CFG_VALID), 64'd0);
        checkOutput("events_outstanding", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
